// File: rtl/sd_spi_responder.sv
// sd_spi_responder
//   SPI-mode SD card responder (SPI mode 0, MSB first) backed by an external
//   byte-wide memory of MEM_BLOCKS x 512 bytes. It understands CMD0, CMD1,
//   CMD55/ACMD41, CMD17 (single block read) and CMD24 (single block write).
//   All SPI inputs are asynchronous and are resampled into clk.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sclk, cs_n, mosi  SPI from the initiator (asynchronous)
//   miso              SPI data to the initiator (1 while cs_n is high)
//   mem_addr          byte address into the backing store
//   mem_rd            read strobe, mem_rdata valid on the following cycle
//   mem_rdata         read data
//   mem_we, mem_wdata single-cycle write strobe and data
//   last_cmd          index of the most recently received command
//   cmd_err           one-cycle pulse on illegal command / address error
module sd_spi_responder #(
  parameter int MEM_BLOCKS = 16,
  parameter int BUSY_BYTES = 4,
  parameter int NCR        = 1,
  localparam int BLK_W     = $clog2(MEM_BLOCKS),
  localparam int AW        = BLK_W + 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic [5:0]    last_cmd,
  output logic          cmd_err
);

  localparam int NCR_LAST  = (NCR > 0) ? NCR - 1 : 0;
  localparam int BUSY_LAST = (BUSY_BYTES > 0) ? BUSY_BYTES - 1 : 0;

  typedef enum logic [3:0] {
    CMD_IDLE, CMD_RX, NCR_GAP, R1_TX, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_t;

  // ---------------------------------------------------------------- sync
  // sclk_sync_reg[2] is the previous synchronized sample, used for edges.
  logic [2:0] sclk_sync_reg;
  logic [1:0] cs_sync_reg;
  logic [1:0] mosi_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= 2'b11;
      mosi_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi};
    end
  end

  logic cs_active, sclk_rise, sclk_fall, mosi_s;
  assign cs_active = ~cs_sync_reg[1];
  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign mosi_s    = mosi_sync_reg[1];

  // ---------------------------------------------------------- bit level
  logic [2:0] bit_cnt_reg;
  logic [7:0] rx_shift_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] tx_load;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte   = {rx_shift_reg[6:0], mosi_s};
  assign byte_done = cs_active & sclk_rise & (bit_cnt_reg == 3'd7);

  // The next byte is loaded on the 8th rise; the fall that follows must not
  // shift it, which is why falls are ignored while bit_cnt_reg is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= 8'hFF;
    end else if (!cs_active) begin
      bit_cnt_reg  <= '0;
      tx_shift_reg <= 8'hFF;
    end else if (sclk_rise) begin
      rx_shift_reg <= rx_byte;
      bit_cnt_reg  <= bit_cnt_reg + 3'd1;
      if (bit_cnt_reg == 3'd7) tx_shift_reg <= tx_load;
    end else if (sclk_fall && bit_cnt_reg != 3'd0) begin
      tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
    end
  end

  assign miso = cs_active ? tx_shift_reg[7] : 1'b1;

  // ----------------------------------------------------- read prefetch
  logic       mem_rd_reg;
  logic       rd_pend_reg;
  logic [7:0] prefetch_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_reg  <= 1'b0;
      prefetch_reg <= '0;
    end else begin
      rd_pend_reg <= mem_rd_reg;
      if (rd_pend_reg) prefetch_reg <= mem_rdata;
    end
  end

  // ------------------------------------------------------------- FSM
  state_t        state_reg, state_next;
  op_t           op_reg, op_next;
  logic          idle_reg, idle_next;
  logic          app_reg, app_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic [8:0]    data_cnt_reg, data_cnt_next;
  logic [5:0]    idx_reg, idx_next;
  logic [AW-1:0] arg_reg, arg_next;      // only the low address bits matter
  logic [7:0]    r1_reg, r1_next;
  logic [BLK_W-1:0] blk_reg, blk_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic          mem_rd_next;
  logic          mem_we_reg, mem_we_next;
  logic [7:0]    mem_wdata_reg, mem_wdata_next;
  logic [5:0]    last_cmd_reg, last_cmd_next;
  logic          cmd_err_reg, cmd_err_next;

  // Command decode, evaluated when the CRC byte of a command completes.
  logic [7:0] r1_dec;
  op_t        op_dec;
  logic       err_dec, idle_dec, app_dec;

  always_comb begin
    r1_dec   = 8'h04;
    op_dec   = OP_NONE;
    err_dec  = 1'b1;
    idle_dec = idle_reg;
    app_dec  = 1'b0;
    if (idx_reg == 6'd0) begin
      r1_dec   = 8'h01;
      err_dec  = 1'b0;
      idle_dec = 1'b1;
    end else if (idx_reg == 6'd55) begin
      r1_dec  = idle_reg ? 8'h01 : 8'h00;
      err_dec = 1'b0;
      app_dec = 1'b1;
    end else if (idx_reg == 6'd1 || (idx_reg == 6'd41 && app_reg)) begin
      r1_dec   = 8'h00;
      err_dec  = 1'b0;
      idle_dec = 1'b0;
    end else if (idx_reg == 6'd17 || idx_reg == 6'd24) begin
      if (idle_reg) begin
        r1_dec = 8'h05;
      end else if (arg_reg[8:0] != 9'd0) begin
        r1_dec = 8'h20;
      end else begin
        r1_dec  = 8'h00;
        err_dec = 1'b0;
        op_dec  = (idx_reg == 6'd17) ? OP_RD : OP_WR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CMD_IDLE;
      op_reg        <= OP_NONE;
      idle_reg      <= 1'b1;
      app_reg       <= 1'b0;
      cnt_reg       <= '0;
      data_cnt_reg  <= '0;
      idx_reg       <= '0;
      arg_reg       <= '0;
      r1_reg        <= 8'hFF;
      blk_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_rd_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      last_cmd_reg  <= '0;
      cmd_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      idle_reg      <= idle_next;
      app_reg       <= app_next;
      cnt_reg       <= cnt_next;
      data_cnt_reg  <= data_cnt_next;
      idx_reg       <= idx_next;
      arg_reg       <= arg_next;
      r1_reg        <= r1_next;
      blk_reg       <= blk_next;
      mem_addr_reg  <= mem_addr_next;
      mem_rd_reg    <= mem_rd_next;
      mem_we_reg    <= mem_we_next;
      mem_wdata_reg <= mem_wdata_next;
      last_cmd_reg  <= last_cmd_next;
      cmd_err_reg   <= cmd_err_next;
    end
  end

  // Each state describes the byte currently on the wire; all decisions are
  // taken when that byte completes, and tx_load is the byte sent next.
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    idle_next      = idle_reg;
    app_next       = app_reg;
    cnt_next       = cnt_reg;
    data_cnt_next  = data_cnt_reg;
    idx_next       = idx_reg;
    arg_next       = arg_reg;
    r1_next        = r1_reg;
    blk_next       = blk_reg;
    mem_addr_next  = mem_addr_reg;
    mem_rd_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_wdata_next = mem_wdata_reg;
    last_cmd_next  = last_cmd_reg;
    cmd_err_next   = 1'b0;
    tx_load        = 8'hFF;

    if (!cs_active) begin
      state_next    = CMD_IDLE;
      cnt_next      = '0;
      data_cnt_next = '0;
    end else if (byte_done) begin
      unique case (state_reg)
        CMD_IDLE: begin
          if (rx_byte[7:6] == 2'b01) begin
            state_next    = CMD_RX;
            idx_next      = rx_byte[5:0];
            last_cmd_next = rx_byte[5:0];
            cnt_next      = 16'd1;
          end
        end
        CMD_RX: begin
          if (cnt_reg < 16'd5) begin
            arg_next = {arg_reg[AW-9:0], rx_byte};
            cnt_next = cnt_reg + 16'd1;
          end else begin
            // CRC byte just completed: act on the command now.
            r1_next       = r1_dec;
            op_next       = op_dec;
            idle_next     = idle_dec;
            app_next      = app_dec;
            cmd_err_next  = err_dec;
            blk_next      = arg_reg[AW-1:9];
            cnt_next      = '0;
            data_cnt_next = '0;
            if (NCR > 0) begin
              state_next = NCR_GAP;
            end else begin
              state_next = R1_TX;
              tx_load    = r1_dec;
            end
          end
        end
        NCR_GAP: begin
          if (cnt_reg == 16'(NCR_LAST)) begin
            state_next = R1_TX;
            tx_load    = r1_reg;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        R1_TX: begin
          if (op_reg == OP_RD)      state_next = RD_GAP;
          else if (op_reg == OP_WR) state_next = WR_TOKEN;
          else                      state_next = CMD_IDLE;
        end
        RD_GAP: begin
          state_next    = RD_TOKEN;
          tx_load       = 8'hFE;
          mem_rd_next   = 1'b1;
          mem_addr_next = {blk_reg, 9'd0};
        end
        RD_TOKEN: begin
          state_next    = RD_DATA;
          tx_load       = prefetch_reg;
          data_cnt_next = '0;
          mem_rd_next   = 1'b1;
          mem_addr_next = {blk_reg, 9'd1};
        end
        RD_DATA: begin
          if (data_cnt_reg == 9'd511) begin
            state_next = RD_CRC;
            cnt_next   = '0;
          end else begin
            tx_load       = prefetch_reg;
            data_cnt_next = data_cnt_reg + 9'd1;
            // Stay one byte ahead; the last two bytes are already fetched.
            if (data_cnt_reg < 9'd510) begin
              mem_rd_next   = 1'b1;
              mem_addr_next = {blk_reg, data_cnt_reg + 9'd2};
            end
          end
        end
        RD_CRC: begin
          if (cnt_reg == 16'd1) state_next = CMD_IDLE;
          else                  cnt_next   = cnt_reg + 16'd1;
        end
        WR_TOKEN: begin
          if (rx_byte == 8'hFE) begin
            state_next    = WR_DATA;
            data_cnt_next = '0;
          end
        end
        WR_DATA: begin
          mem_we_next    = 1'b1;
          mem_wdata_next = rx_byte;
          mem_addr_next  = {blk_reg, data_cnt_reg};
          if (data_cnt_reg == 9'd511) begin
            state_next = WR_CRC;
            cnt_next   = '0;
          end else begin
            data_cnt_next = data_cnt_reg + 9'd1;
          end
        end
        WR_CRC: begin
          if (cnt_reg == 16'd1) begin
            state_next = WR_RESP;
            tx_load    = 8'h05;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        WR_RESP: begin
          if (BUSY_BYTES > 0) begin
            state_next = WR_BUSY;
            tx_load    = 8'h00;
          end else begin
            state_next = CMD_IDLE;
          end
        end
        WR_BUSY: begin
          if (cnt_reg == 16'(BUSY_LAST)) begin
            state_next = CMD_IDLE;
          end else begin
            cnt_next = cnt_reg + 16'd1;
            tx_load  = 8'h00;
          end
        end
        default: state_next = CMD_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_rd    = mem_rd_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;
  assign last_cmd  = last_cmd_reg;
  assign cmd_err   = cmd_err_reg;

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter MEM_BLOCKS, default 16, number of 512-byte blocks in the backing store (power of two).
REQ-002 Parameter BUSY_BYTES, default 4, number of 0x00 busy bytes sent after a write data-response.
REQ-003 Parameter NCR, default 1, number of 0xFF filler bytes between the last command byte and R1.
REQ-004 clk  in  1  system clock, 100 MHz; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 sclk  in  1  SPI clock from the initiator, asynchronous, frequency at most clk/4.
REQ-007 cs_n  in  1  SPI chip select, active low, asynchronous.
REQ-008 mosi  in  1  command and data from the initiator.
REQ-009 miso  out  1  response and data to the initiator.
REQ-010 mem_addr  out  $clog2(MEM_BLOCKS)+9  byte address into the backing store.
REQ-011 mem_rd  out  1  read strobe; mem_rdata is valid on the cycle after.
REQ-012 mem_rdata  in  8  read data.
REQ-013 mem_we  out  1  single-cycle write strobe.
REQ-014 mem_wdata  out  8  write data.
REQ-015 last_cmd  out  6  index of the most recently decoded command.
REQ-016 cmd_err  out  1  single-cycle pulse on an illegal command or an address error.

Function
REQ-017 sclk, cs_n and mosi SHALL each pass through a 2-FF synchronizer; sclk edges SHALL be detected from the synchronized copy.
REQ-018 Bit order SHALL be MSB first (SPI mode 0):
- mosi sampled on the detected sclk rise.
- miso updated on the detected sclk fall.
- The first miso bit of a byte is driven as soon as the byte is loaded.
REQ-019 While cs_n is high:
- miso = 1.
- Bit counter cleared.
- FSM forced to CMD_IDLE.
- Any partial transaction is abandoned; bytes already written stay written.
REQ-020 FSM states: CMD_IDLE, CMD_RX, NCR_GAP, R1_TX, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
REQ-021 CMD_IDLE → CMD_RX on the first received byte whose bits [7:6] = 01; other bytes are ignored and answered with 0xFF.
REQ-022 CMD_RX SHALL collect 6 bytes total (index, 32-bit big-endian argument, CRC); the CRC is not checked.
REQ-023 After the 6th byte, the FSM SHALL send NCR bytes of 0xFF, then R1 in R1_TX.
REQ-024 R1 values:
- CMD0 → 0x01, and idle flag set.
- CMD55 → 0x01 if idle, else 0x00.
- ACMD41 or CMD1 → 0x00, and idle flag cleared.
- CMD17/CMD24 → 0x00 if the argument is aligned, else 0x20 (address error) with cmd_err.
- Any other command → 0x04 (illegal) with cmd_err.
- CMD17/CMD24 issued while idle → 0x05 with cmd_err.
REQ-025 Block index SHALL be argument[31:9] modulo MEM_BLOCKS; "aligned" means argument[8:0] = 0.
REQ-026 CMD17 read sequence:
- R1_TX → RD_GAP: one 0xFF byte.
- RD_TOKEN: sends 0xFE.
- RD_DATA: sends 512 bytes from mem, byte 0 first.
- RD_CRC: sends 0xFF, 0xFF.
- Then → CMD_IDLE.
REQ-027 Each read byte SHALL be fetched with mem_rd at least 2 clk before it is loaded into the shift register.
REQ-028 CMD24 write sequence:
- R1_TX → WR_TOKEN: miso 0xFF; wait for a received 0xFE, ignoring other bytes.
- WR_DATA: each received byte gives one mem_we pulse, with mem_addr incrementing from block base.
- WR_CRC: 2 bytes received and discarded.
- WR_RESP: sends 0x05.
- WR_BUSY: sends BUSY_BYTES bytes of 0x00.
- Then → CMD_IDLE, with miso 0xFF.
REQ-029 The 9-bit data byte counter SHALL terminate at 511; mem_addr SHALL never cross the block boundary.
REQ-030 last_cmd SHALL update on the clk after the command index byte completes.
REQ-031 A new command-start byte received during RD_* or WR_* SHALL NOT be decoded; only cs_n high aborts a transaction.
REQ-032 mem_we and mem_rd SHALL each be asserted at most once per SPI byte.

Reset
REQ-033 On rst, all of the following SHALL hold:
- state = CMD_IDLE, idle flag = 1.
- miso = 1, mem_we = 0, mem_rd = 0.
- mem_addr = 0, mem_wdata = 0.
- last_cmd = 0, cmd_err = 0.
- Bit and byte counters = 0.
REQ-034 rst asserted mid-transfer SHALL take effect on the next clk, regardless of cs_n or sclk.

Verification
REQ-035 Init: CMD0 (0x40 00 00 00 00 95), clock 0xFF bytes → R1 0x01 after NCR filler; then CMD55 → 0x01; ACMD41 → 0x00; a second CMD55 → 0x00.
REQ-036 Write: after init, CMD24 arg 0x00000400 → R1 0x00; send token 0xFE, bytes 0x00..0xFF twice, CRC → response 0x05, then 4×0x00, then 0xFF; mem bytes 1024..1535 = pattern.
REQ-037 Read-back: CMD17 arg 0x00000400 → 0x00, 0xFF, 0xFE, the 512-byte pattern, 0xFF, 0xFF; mem_rd count = 512.
REQ-038 Errors:
- CMD17 arg 0x00000401 → R1 0x20 with one cmd_err pulse, no token.
- CMD9 → R1 0x04.
- CMD17 before ACMD41 → 0x05.
REQ-039 Abort: raise cs_n after 100 CMD24 data bytes → exactly 100 mem_we pulses, miso = 1; the next CMD0 is answered normally.
REQ-040 Wrap: CMD24 arg 16×512 with MEM_BLOCKS=16 → writes land at block 0; rst mid-read → miso = 1 and state = CMD_IDLE on the next clk.
